// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a debug/loader port.
// CPU path is combinational (0 cycles); debug is served in idle cycles or preempts the CPU after STARVE_MAX waits.
module dm_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_BYTES  = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_re_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'(MEM_BYTES - 4);
  localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {S_IDLE, S_ACK} state_e;

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic cpu_act, cpu_legal, dbg_legal, dbg_elig, dbg_gnt, cpu_gnt;

  assign cpu_act   = cpu_re_i | cpu_we_i;
  assign cpu_legal = (cpu_addr_i[1:0] == 2'b00) && (cpu_addr_i <= MAX_ADDR);
  assign dbg_legal = (dbg_addr_i[1:0] == 2'b00) && (dbg_addr_i <= MAX_ADDR);
  assign dbg_elig  = dbg_req_i && (state_q == S_IDLE);
  assign dbg_gnt   = dbg_elig && (!cpu_act || (starve_q == STARVE_LIM));
  assign cpu_gnt   = cpu_act && !dbg_gnt;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    ack_d       = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    cpu_rdata_o = '0;
    cpu_stall_o = 1'b0;

    case (state_q)
      S_IDLE:  if (dbg_gnt) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (dbg_gnt) begin
      starve_d    = '0;
      cpu_stall_o = cpu_act;
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
      mem_we_o    = dbg_legal && dbg_we_i;
      mem_re_o    = dbg_legal && !dbg_we_i;
      ack_d       = 1'b1;
      err_d       = !dbg_legal;
      rdata_d     = (dbg_legal && !dbg_we_i) ? mem_rdata_i : '0;
    end else begin
      if (dbg_elig && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
      if (cpu_gnt) begin
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        // A simultaneous read+write request is executed as a write only.
        mem_we_o    = cpu_legal && cpu_we_i;
        mem_re_o    = cpu_legal && cpu_re_i && !cpu_we_i;
        cpu_rdata_o = cpu_legal ? mem_rdata_i : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dbg_ack_o   = ack_q;
  assign dbg_err_o   = err_q;
  assign dbg_rdata_o = rdata_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small behavioural data memory behind it.
module tb_dm_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_re_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        cpu_stall_o;
  logic        dbg_req_i, dbg_we_i;
  logic [31:0] dbg_addr_i, dbg_wdata_i, dbg_rdata_o;
  logic        dbg_ack_o, dbg_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_re_o, mem_we_o;

  logic [31:0] mem [0:31] = '{default: 32'h0};
  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  assign mem_rdata_i = mem[mem_addr_o[6:2]];
  always @(posedge clk_i) if (mem_we_o) mem[mem_addr_o[6:2]] <= mem_wdata_o;

  dm_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(128), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_re_i(cpu_re_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
    .dbg_err_o(dbg_err_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i)
  );

  // Inputs change 1 time unit after the rising edge; all checks sample there too.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_re_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
    dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 0;
    #12;
    total++; if (dbg_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", dbg_ack_o); end
    total++; if (dbg_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", dbg_rdata_o); end
    total++; if (dbg_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", dbg_err_o); end
    total++; if (cpu_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", cpu_stall_o); end
    total++; if ({mem_re_o, mem_we_o} !== 2'b00) begin bad++; $display("FAIL reset_mem_en got=%b exp=00", {mem_re_o, mem_we_o}); end
    @(negedge clk_i);
    rst_i = 1;
    step();
  endtask

  task automatic test_cpu_only();
    cpu_we_i = 1; cpu_addr_i = 8; cpu_wdata_i = 32'hAB;
    #1;
    total++; if ({mem_we_o, mem_re_o} !== 2'b10) begin bad++; $display("FAIL cpu_wr_en got=%b exp=10", {mem_we_o, mem_re_o}); end
    total++; if (mem_addr_o !== 32'd8) begin bad++; $display("FAIL cpu_wr_addr got=%h exp=8", mem_addr_o); end
    total++; if (cpu_stall_o !== 1'b0) begin bad++; $display("FAIL cpu_wr_stall got=%b exp=0", cpu_stall_o); end
    step();
    cpu_we_i = 0; cpu_re_i = 1;
    #1;
    total++; if (cpu_rdata_o !== 32'hAB) begin bad++; $display("FAIL cpu_rd_data got=%h exp=000000ab", cpu_rdata_o); end
    total++; if (mem_re_o !== 1'b1) begin bad++; $display("FAIL cpu_rd_en got=%b exp=1", mem_re_o); end
    total++; if (cpu_stall_o !== 1'b0) begin bad++; $display("FAIL cpu_rd_stall got=%b exp=0", cpu_stall_o); end
    step();
    cpu_we_i = 1; cpu_re_i = 1; cpu_addr_i = 12; cpu_wdata_i = 32'h55;
    #1;
    total++; if ({mem_we_o, mem_re_o} !== 2'b10) begin bad++; $display("FAIL cpu_rw_en got=%b exp=10", {mem_we_o, mem_re_o}); end
    step();
    idle_inputs();
    total++; if (mem[3] !== 32'h55) begin bad++; $display("FAIL cpu_rw_commit got=%h exp=00000055", mem[3]); end
  endtask

  task automatic test_dbg_idle();
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 16; dbg_wdata_i = 32'h1234;
    #1;
    total++; if ({mem_we_o, mem_addr_o} !== {1'b1, 32'd16}) begin bad++; $display("FAIL dbg_wr_mem got=%b/%h exp=1/10", mem_we_o, mem_addr_o); end
    step();
    total++; if ({dbg_ack_o, dbg_err_o} !== 2'b10) begin bad++; $display("FAIL dbg_wr_ack got=%b exp=10", {dbg_ack_o, dbg_err_o}); end
    dbg_we_i = 0;
    #1;
    total++; if (mem_re_o !== 1'b0) begin bad++; $display("FAIL dbg_ack_block got=%b exp=0", mem_re_o); end
    step();
    total++; if (dbg_ack_o !== 1'b0) begin bad++; $display("FAIL dbg_ack_gap got=%b exp=0", dbg_ack_o); end
    step();
    total++; if ({dbg_ack_o, dbg_err_o} !== 2'b10) begin bad++; $display("FAIL dbg_rd_ack got=%b exp=10", {dbg_ack_o, dbg_err_o}); end
    total++; if (dbg_rdata_o !== 32'h1234) begin bad++; $display("FAIL dbg_rd_data got=%h exp=00001234", dbg_rdata_o); end
    idle_inputs();
    step();
  endtask

  task automatic test_starve();
    cpu_re_i = 1; cpu_addr_i = 8;
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 16;
    for (int round = 0; round < 2; round++) begin
      for (int k = 1; k <= 5; k++) begin
        #1;
        total++; if (cpu_stall_o !== (k == 5)) begin bad++; $display("FAIL starve_stall r%0d k%0d got=%b exp=%b", round, k, cpu_stall_o, k == 5); end
        total++; if (cpu_rdata_o !== ((k == 5) ? 32'h0 : 32'hAB)) begin bad++; $display("FAIL starve_cpu_rd r%0d k%0d got=%h", round, k, cpu_rdata_o); end
        step();
      end
      total++; if ({dbg_ack_o, dbg_rdata_o} !== {1'b1, 32'h1234}) begin bad++; $display("FAIL starve_ack r%0d got=%b/%h exp=1/00001234", round, dbg_ack_o, dbg_rdata_o); end
      total++; if (cpu_stall_o !== 1'b0) begin bad++; $display("FAIL starve_ack_stall r%0d got=%b exp=0", round, cpu_stall_o); end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_illegal();
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 6;
    #1;
    total++; if (mem_re_o !== 1'b0) begin bad++; $display("FAIL ill_dbg_mem_re got=%b exp=0", mem_re_o); end
    step();
    total++; if ({dbg_ack_o, dbg_err_o, dbg_rdata_o} !== {2'b11, 32'h0}) begin bad++; $display("FAIL ill_dbg_ack got=%b%b/%h exp=11/0", dbg_ack_o, dbg_err_o, dbg_rdata_o); end
    idle_inputs();
    step();
    cpu_we_i = 1; cpu_addr_i = 128; cpu_wdata_i = 32'hDEAD;
    #1;
    total++; if ({mem_we_o, cpu_stall_o} !== 2'b00) begin bad++; $display("FAIL ill_cpu_we got=%b exp=00", {mem_we_o, cpu_stall_o}); end
    step();
    total++; if (mem[0] !== 32'h0) begin bad++; $display("FAIL ill_cpu_mem got=%h exp=0", mem[0]); end
    cpu_we_i = 0; cpu_re_i = 1; cpu_addr_i = 10;
    #1;
    total++; if ({mem_re_o, cpu_rdata_o} !== {1'b0, 32'h0}) begin bad++; $display("FAIL ill_cpu_rd got=%b/%h exp=0/0", mem_re_o, cpu_rdata_o); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] acks;
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 20; dbg_wdata_i = 32'h77;
    for (int i = 0; i < 4; i++) begin
      step();
      acks[i] = dbg_ack_o;
    end
    total++; if (acks !== 4'b0101) begin bad++; $display("FAIL held_ack_seq got=%b exp=0101", acks); end
    idle_inputs();
    step();
    total++; if (dbg_ack_o !== 1'b0) begin bad++; $display("FAIL held_release got=%b exp=0", dbg_ack_o); end
  endtask

  task automatic test_reset_in_ack();
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 24; dbg_wdata_i = 32'h99;
    step();
    total++; if (dbg_ack_o !== 1'b1) begin bad++; $display("FAIL rst_ack_pre got=%b exp=1", dbg_ack_o); end
    #1;
    rst_i = 0;
    #1;
    total++; if ({dbg_ack_o, dbg_err_o, dbg_rdata_o} !== 34'h0) begin bad++; $display("FAIL rst_ack_drop got=%b%b/%h exp=00/0", dbg_ack_o, dbg_err_o, dbg_rdata_o); end
    idle_inputs();
    step();
    @(negedge clk_i);
    rst_i = 1;
    step();
    cpu_re_i = 1; cpu_addr_i = 24;
    #1;
    total++; if ({cpu_stall_o, cpu_rdata_o} !== {1'b0, 32'h99}) begin bad++; $display("FAIL rst_cpu_first got=%b/%h exp=0/00000099", cpu_stall_o, cpu_rdata_o); end
    total++; if (dbg_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack_after got=%b exp=0", dbg_ack_o); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_dbg_idle();
    test_starve();
    test_illegal();
    test_back_to_back();
    test_reset_in_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
